// File: rtl/stride_counter_if.sv
// Pixel-stream, configuration and window-status signals exchanged between the
// front end (master) and the stride counter (slave).
interface stride_counter_if #(
    parameter int CNT_WIDTH = 8,
    parameter int KS_WIDTH  = 4
);
    logic                 STRIDE_COUNTER_Start;
    logic [CNT_WIDTH-1:0] STRIDE_COUNTER_Img_Width;
    logic [CNT_WIDTH-1:0] STRIDE_COUNTER_Img_Height;
    logic [KS_WIDTH-1:0]  STRIDE_COUNTER_Kernel_Size;
    logic [KS_WIDTH-1:0]  STRIDE_COUNTER_Stride;
    logic                 STRIDE_COUNTER_Pixel_Valid;
    logic                 STRIDE_COUNTER_Counter_Eqst_Clr;
    logic                 STRIDE_COUNTER_Eqst_Flag;
    logic [CNT_WIDTH-1:0] STRIDE_COUNTER_Col;
    logic [CNT_WIDTH-1:0] STRIDE_COUNTER_Row;
    logic                 STRIDE_COUNTER_Busy;
    logic                 STRIDE_COUNTER_Done;
    logic                 STRIDE_COUNTER_Cfg_Err;

    modport master (
        output STRIDE_COUNTER_Start, STRIDE_COUNTER_Img_Width, STRIDE_COUNTER_Img_Height,
               STRIDE_COUNTER_Kernel_Size, STRIDE_COUNTER_Stride, STRIDE_COUNTER_Pixel_Valid,
               STRIDE_COUNTER_Counter_Eqst_Clr,
        input  STRIDE_COUNTER_Eqst_Flag, STRIDE_COUNTER_Col, STRIDE_COUNTER_Row,
               STRIDE_COUNTER_Busy, STRIDE_COUNTER_Done, STRIDE_COUNTER_Cfg_Err
    );

    modport slave (
        input  STRIDE_COUNTER_Start, STRIDE_COUNTER_Img_Width, STRIDE_COUNTER_Img_Height,
               STRIDE_COUNTER_Kernel_Size, STRIDE_COUNTER_Stride, STRIDE_COUNTER_Pixel_Valid,
               STRIDE_COUNTER_Counter_Eqst_Clr,
        output STRIDE_COUNTER_Eqst_Flag, STRIDE_COUNTER_Col, STRIDE_COUNTER_Row,
               STRIDE_COUNTER_Busy, STRIDE_COUNTER_Done, STRIDE_COUNTER_Cfg_Err
    );
endinterface

// File: rtl/stride_counter.sv
// Tracks convolution-window position over a streamed feature map and pulses
// Eqst_Flag one cycle after each pixel that completes a stride-aligned window.
module stride_counter #(
    parameter int CNT_WIDTH = 8,
    parameter int KS_WIDTH  = 4
) (
    input  logic            STRIDE_COUNTER_Clk,
    input  logic            STRIDE_COUNTER_Reset,
    stride_counter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next_state;

    logic [CNT_WIDTH-1:0] r_width;
    logic [CNT_WIDTH-1:0] r_height;
    logic [KS_WIDTH-1:0]  r_kernel;
    logic [KS_WIDTH-1:0]  r_stride;
    logic [CNT_WIDTH-1:0] r_col;
    logic [CNT_WIDTH-1:0] r_row;
    logic [KS_WIDTH-1:0]  r_hs;
    logic [KS_WIDTH-1:0]  r_vs;
    logic                 r_flag;
    logic                 r_cfg_err;

    logic [CNT_WIDTH-1:0] w_in_kernel;
    logic                 w_cfg_ok;
    logic                 w_start_ok;
    logic                 w_start_bad;
    logic                 w_pixel;
    logic [CNT_WIDTH-1:0] w_k_m1;
    logic [KS_WIDTH-1:0]  w_s_m1;
    logic                 w_col_last;
    logic                 w_row_last;
    logic                 w_col_in;
    logic                 w_row_in;
    logic                 w_hit;
    logic [KS_WIDTH-1:0]  w_hs_next;
    logic [KS_WIDTH-1:0]  w_vs_next;

    // K is zero-extended so all window compares happen at image-dimension width
    assign w_in_kernel = CNT_WIDTH'(bus.STRIDE_COUNTER_Kernel_Size);
    assign w_cfg_ok    = (bus.STRIDE_COUNTER_Stride != '0) && (w_in_kernel != '0) &&
                         (w_in_kernel <= bus.STRIDE_COUNTER_Img_Width) &&
                         (w_in_kernel <= bus.STRIDE_COUNTER_Img_Height);
    assign w_start_ok  = (r_state == IDLE) && bus.STRIDE_COUNTER_Start && w_cfg_ok;
    assign w_start_bad = (r_state == IDLE) && bus.STRIDE_COUNTER_Start && !w_cfg_ok;

    assign w_pixel    = (r_state == RUN) && bus.STRIDE_COUNTER_Pixel_Valid;
    assign w_k_m1     = CNT_WIDTH'(r_kernel) - CNT_WIDTH'(1);
    assign w_s_m1     = r_stride - KS_WIDTH'(1);
    assign w_col_last = (r_col == r_width - CNT_WIDTH'(1));
    assign w_row_last = (r_row == r_height - CNT_WIDTH'(1));
    assign w_col_in   = (r_col >= w_k_m1);
    assign w_row_in   = (r_row >= w_k_m1);
    assign w_hit      = w_pixel && w_col_in && w_row_in && (r_hs == '0) && (r_vs == '0);
    assign w_hs_next  = (r_hs == w_s_m1) ? '0 : r_hs + KS_WIDTH'(1);
    assign w_vs_next  = (r_vs == w_s_m1) ? '0 : r_vs + KS_WIDTH'(1);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_start_ok) w_next_state = RUN;
            RUN:     if (w_pixel && w_col_last && w_row_last) w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge STRIDE_COUNTER_Clk) begin
        if (STRIDE_COUNTER_Reset) begin
            r_state   <= IDLE;
            r_width   <= '0;
            r_height  <= '0;
            r_kernel  <= '0;
            r_stride  <= '0;
            r_col     <= '0;
            r_row     <= '0;
            r_hs      <= '0;
            r_vs      <= '0;
            r_flag    <= 1'b0;
            r_cfg_err <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_flag    <= w_hit;
            r_cfg_err <= w_start_bad;
            if (w_start_ok) begin
                r_width  <= bus.STRIDE_COUNTER_Img_Width;
                r_height <= bus.STRIDE_COUNTER_Img_Height;
                r_kernel <= bus.STRIDE_COUNTER_Kernel_Size;
                r_stride <= bus.STRIDE_COUNTER_Stride;
                r_col    <= '0;
                r_row    <= '0;
                r_hs     <= '0;
                r_vs     <= '0;
            end else begin
                if (w_pixel) begin
                    if (w_col_last) begin
                        r_col <= '0;
                        r_row <= w_row_last ? '0 : r_row + CNT_WIDTH'(1);
                        if (w_row_in) r_vs <= w_vs_next;
                    end else begin
                        r_col <= r_col + CNT_WIDTH'(1);
                    end
                end
                // The external clear wins over both the advance and the column-wrap reset
                if (bus.STRIDE_COUNTER_Counter_Eqst_Clr) begin
                    r_hs <= '0;
                end else if (w_pixel) begin
                    if (w_col_last)    r_hs <= '0;
                    else if (w_col_in) r_hs <= w_hs_next;
                end
            end
        end
    end

    assign bus.STRIDE_COUNTER_Eqst_Flag = r_flag;
    assign bus.STRIDE_COUNTER_Col       = r_col;
    assign bus.STRIDE_COUNTER_Row       = r_row;
    assign bus.STRIDE_COUNTER_Busy      = (r_state == RUN);
    assign bus.STRIDE_COUNTER_Done      = (r_state == DONE);
    assign bus.STRIDE_COUNTER_Cfg_Err   = r_cfg_err;

endmodule

// File: doc/stride_counter.md
Name: stride_counter

Overview:
- Generates the stride-equal flag that drives the counter clear block.
- Tracks convolution-window position over a streamed input feature map: counts column/row per accepted pixel and applies kernel-size and stride rules.
- Pulses Eqst_Flag on each pixel that completes a valid, stride-aligned window.
- Accepts the returned Counter_Eqst_Clr to resynchronise its horizontal stride counter; sits between the pixel-stream front end and the MAC/window control.

Parameters:
CNT_WIDTH, 8, width of image dimension inputs and Col/Row counters
KS_WIDTH, 4, width of Kernel_Size and Stride inputs

Ports:
STRIDE_COUNTER_Clk  in  1  system clock, all logic on rising edge
STRIDE_COUNTER_Reset  in  1  synchronous, active-high reset
STRIDE_COUNTER_Start  in  1  one-cycle pulse; latches config in IDLE
STRIDE_COUNTER_Img_Width  in  CNT_WIDTH  image columns W
STRIDE_COUNTER_Img_Height  in  CNT_WIDTH  image rows H
STRIDE_COUNTER_Kernel_Size  in  KS_WIDTH  kernel side K
STRIDE_COUNTER_Stride  in  KS_WIDTH  stride S
STRIDE_COUNTER_Pixel_Valid  in  1  one pixel accepted this cycle
STRIDE_COUNTER_Counter_Eqst_Clr  in  1  external clear of horizontal stride counter
STRIDE_COUNTER_Eqst_Flag  out  1  registered window-aligned pulse
STRIDE_COUNTER_Col  out  CNT_WIDTH  column of next expected pixel
STRIDE_COUNTER_Row  out  CNT_WIDTH  row of next expected pixel
STRIDE_COUNTER_Busy  out  1  high in RUN
STRIDE_COUNTER_Done  out  1  one-cycle pulse after last pixel
STRIDE_COUNTER_Cfg_Err  out  1  one-cycle pulse on rejected config

Behaviour:
- Clock/reset: one clock; reset is synchronous and active-high. Reset has priority over all other inputs, including mid-RUN. Reset forces all outputs to 0, all counters to 0, state to IDLE.
- FSM states: IDLE, RUN, DONE.
- IDLE, Start=1, config valid: latch W, H, K, S; clear col/row/hs/vs; go to RUN next cycle.
- Config is valid when S>=1, K>=1, K<=W and K<=H.
- IDLE, Start=1, config invalid: Cfg_Err=1 for one cycle; stay in IDLE; Busy stays 0.
- Start in RUN or DONE: ignored. Pixel_Valid outside RUN: ignored.
- RUN, pixel with Pixel_Valid=1:
  - If col<W-1: col+1.
  - Else: col=0. Then, if row<H-1: row+1; otherwise, next state is DONE.
- Horizontal stride counter hs (0..S-1):
  - Advances only on valid pixels with col>=K-1: hs = (hs==S-1) ? 0 : hs+1.
  - Resets to 0 on column wrap.
- Vertical stride counter vs (0..S-1):
  - Advances on column wrap when row>=K-1, same modulo rule.
- Window hit: valid pixel with col>=K-1, row>=K-1, hs==0 and vs==0, all evaluated on the pre-update values.
- Eqst_Flag: registered, high exactly one cycle after a hit pixel (latency 1). Low otherwise.
- Counter_Eqst_Clr:
  - With no valid pixel that cycle: hs becomes 0 next edge.
  - With a valid pixel the same cycle: the pixel is evaluated with the current hs, then hs becomes 0 instead of advancing.
  - Col/Row/vs are unaffected.
- DONE: Done=1 for one cycle, Busy=0; return to IDLE.
- Busy=1 exactly while in RUN.
- Col/Row hold through Pixel_Valid gaps and hold their final values (0,0 after wrap) in IDLE until the next Start.
- Expected flag count per frame: (floor((W-K)/S)+1) * (floor((H-K)/S)+1), when Clr is never asserted.
- Widths: compares are unsigned at CNT_WIDTH; K and S are zero-extended.

Test Plan:
1. W=H=5, K=3, S=1, 25 back-to-back valids -> 9 Eqst_Flag pulses, first one cycle after pixel index 12 (row2,col2). Done one cycle after the RUN->DONE transition; Busy low after.
2. W=H=5, K=3, S=2 -> exactly 4 pulses, after pixel indices 12, 14, 22, 24.
3. Case 1 with random 0–3 cycle gaps in Pixel_Valid -> same 9 pulses relative to pixel index; Col/Row hold during gaps.
4. Start with S=0, then Start with K=6 and W=5 -> Cfg_Err pulses each time; Busy=0; Col=Row=0; no flags.
5. W=8, H=1, K=1, S=3, Clr asserted together with the col1 pixel -> flags at cols 0, 2, 5 (instead of 0, 3, 6).
6. Reset asserted one cycle after pixel index 10 of case 1 -> all outputs 0 next edge, IDLE. A fresh Start then reproduces case 1 exactly.
